// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the 8:1 x 3-bit mux selects and registers the chosen word.
// Optional MUX8_ARB_LOCK_EN adds a lock input that lifts the burst limit while held.
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [2:0] i0,
    input  logic [2:0] i1,
    input  logic [2:0] i2,
    input  logic [2:0] i3,
    input  logic [2:0] i4,
    input  logic [2:0] i5,
    input  logic [2:0] i6,
    input  logic [2:0] i7,
`ifdef MUX8_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [7:0] gnt,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [2:0] f,
    output logic       f_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BURST);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [2:0]        sel_q;
    logic [2:0]        ptr;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        din [8];
    logic [2:0]        cur_word;
    logic              cur_req;
    logic              under_lim;
    logic              lock_act;
    logic              xfer;
    logic              rel;
    logic              arb_hit;
    logic [2:0]        arb_idx;
    logic [2:0]        scan_idx;

`ifdef MUX8_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign din[0] = i0;
    assign din[1] = i1;
    assign din[2] = i2;
    assign din[3] = i3;
    assign din[4] = i4;
    assign din[5] = i5;
    assign din[6] = i6;
    assign din[7] = i7;

    assign cur_word  = din[sel_q];
    assign cur_req   = req[sel_q];
    assign under_lim = (cnt < MAXC);

    // Scan starts at ptr so the last released requester is considered last.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = 3'd0;
        scan_idx = 3'd0;
        for (int o = 0; o < 8; o++) begin
            scan_idx = ptr + 3'(o);
            if (!arb_hit && req[scan_idx]) begin
                arb_hit = 1'b1;
                arb_idx = scan_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; xfer and rel are mutually exclusive by construction.
    always_comb begin
        xfer      = (state == GRANT) && cur_req && (under_lim || lock_act);
        rel       = (state == GRANT) && (!cur_req || (!under_lim && !lock_act));
        state_nxt = state;
        case (state)
            IDLE:    if (arb_hit) state_nxt = GRANT;
            GRANT:   if (rel)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= 8'd0;
            sel_q   <= 3'd0;
            f       <= 3'd0;
            f_valid <= 1'b0;
            ptr     <= 3'd0;
            cnt     <= '0;
        end else begin
            f_valid <= xfer;
            if (xfer) begin
                f   <= cur_word;
                cnt <= under_lim ? cnt + 1'b1 : cnt;
            end
            if (state == IDLE && arb_hit) begin
                gnt   <= 8'd1 << arb_idx;
                sel_q <= arb_idx;
                cnt   <= '0;
            end
            if (rel) begin
                gnt <= 8'd0;
                ptr <= sel_q + 3'd1;
            end
        end
    end

    // Output decode; selects stay at the last granted index while idle.
    always_comb begin
        busy = (state == GRANT);
        s3   = sel_q[2];
        s1   = sel_q[1];
        s2   = sel_q[0];
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, single grant, round-robin order, wrap, reset mid-burst, early drop, burst limit/lock.
module tb_mux8_rr_arbiter;

    localparam int MB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] i0, i1, i2, i3, i4, i5, i6, i7;
    logic [7:0] gnt;
    logic       s1, s2, s3;
    logic [2:0] f;
    logic       f_valid;
    logic       busy;
`ifdef MUX8_ARB_LOCK_EN
    logic       lock;
`endif

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.MAX_BURST(MB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
`ifdef MUX8_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .s1(s1), .s2(s2), .s3(s3), .f(f), .f_valid(f_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks grant, selects, valid and busy in one go.
    task automatic chk_gs(input string tag, input logic [7:0] eg, input logic [2:0] es,
                          input logic efv, input logic ebusy);
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_sel"}, {5'd0, s3, s1, s2}, {5'd0, es});
        chk({tag, "_fv"}, {7'd0, f_valid}, {7'd0, efv});
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, ebusy});
    endtask

    initial begin
        rst = 1'b1; req = 8'h00;
        i0 = 3'd0; i1 = 3'd1; i2 = 3'd2; i3 = 3'd3;
        i4 = 3'd4; i5 = 3'd5; i6 = 3'd6; i7 = 3'd7;
`ifdef MUX8_ARB_LOCK_EN
        lock = 1'b0;
`endif
        tick();
        tick();
        chk_gs("rst", 8'h00, 3'b000, 1'b0, 1'b0);
        chk("rst_f", {5'd0, f}, 8'h00);
        rst = 1'b0;

        // Test 1: single requester 2, three words
        req = 8'h04; i2 = 3'b101;
        tick();
        chk_gs("t1_grant", 8'h04, 3'b010, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_gs("t1_xfer", 8'h04, 3'b010, 1'b1, 1'b1);
            chk("t1_f", {5'd0, f}, 8'h05);
        end
        req = 8'h00;
        tick();
        chk_gs("t1_rel", 8'h00, 3'b010, 1'b0, 1'b0);
        chk("t1_fhold", {5'd0, f}, 8'h05);
        req = 8'h0C;                       // ptr now 3: index 3 must beat index 2
        tick();
        chk_gs("t1_ptr3", 8'h08, 3'b011, 1'b0, 1'b1);
        req = 8'h00;
        tick();
        chk_gs("t1_rel2", 8'h00, 3'b011, 1'b0, 1'b0);
        i2 = 3'd2;

        // Test 2: all requesting, full rotation plus wrap to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            logic [2:0] k;
            k = 3'(g % 8);
            tick();
            chk_gs("t2_grant", 8'd1 << k, k, 1'b0, 1'b1);
            for (int n = 0; n < MB; n++) begin
                tick();
                chk("t2_fv", {7'd0, f_valid}, 8'h01);
                chk("t2_f", {5'd0, f}, {5'd0, k});
            end
            tick();
            chk_gs("t2_rel", 8'h00, k, 1'b0, 1'b0);
        end
        req = 8'h00;

        // Test 3: wrap from 7 to 0
        req = 8'h40;
        tick();
        chk_gs("t3_g6", 8'h40, 3'b110, 1'b0, 1'b1);
        req = 8'h00;
        tick();
        chk_gs("t3_rel6", 8'h00, 3'b110, 1'b0, 1'b0);
        req = 8'h81;
        tick();
        chk_gs("t3_g7", 8'h80, 3'b111, 1'b0, 1'b1);
        for (int n = 0; n < MB; n++) begin
            tick();
            chk("t3_f7", {4'd0, f_valid, f}, 8'h0F);
        end
        tick();
        chk_gs("t3_rel7", 8'h00, 3'b111, 1'b0, 1'b0);
        tick();
        chk_gs("t3_g0", 8'h01, 3'b000, 1'b0, 1'b1);
        req = 8'h00;
        tick();
        chk_gs("t3_rel0", 8'h00, 3'b000, 1'b0, 1'b0);

        // Test 4: reset mid-burst on index 5 (ptr is 1 beforehand)
        req = 8'h20;
        tick();
        chk_gs("t4_g5", 8'h20, 3'b101, 1'b0, 1'b1);
        tick();
        tick();
        chk("t4_f5", {4'd0, f_valid, f}, 8'h0D);
        rst = 1'b1;
        tick();
        chk_gs("t4_rst", 8'h00, 3'b000, 1'b0, 1'b0);
        chk("t4_rst_f", {5'd0, f}, 8'h00);
        rst = 1'b0;
        req = 8'h21;
        tick();
        chk_gs("t4_g0", 8'h01, 3'b000, 1'b0, 1'b1);
        req = 8'h00;
        tick();
        chk_gs("t4_rel", 8'h00, 3'b000, 1'b0, 1'b0);

        // Test 5: requester 1 leaves after one word, 2 waits one idle cycle
        req = 8'h06;
        tick();
        chk_gs("t5_g1", 8'h02, 3'b001, 1'b0, 1'b1);
        tick();
        chk("t5_f1", {4'd0, f_valid, f}, 8'h09);
        req = 8'h04;
        tick();
        chk_gs("t5_rel1", 8'h00, 3'b001, 1'b0, 1'b0);
        tick();
        chk_gs("t5_g2", 8'h04, 3'b010, 1'b0, 1'b1);
        req = 8'h00;
        tick();
        chk_gs("t5_rel2", 8'h00, 3'b010, 1'b0, 1'b0);

        // Test 6: requester 3 held for a long burst
        req = 8'h08;
`ifdef MUX8_ARB_LOCK_EN
        lock = 1'b1;
        tick();
        chk_gs("t6_g3", 8'h08, 3'b011, 1'b0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("t6_lockf", {4'd0, f_valid, f}, 8'h0B);
        end
        req = 8'h00;
        tick();
        chk_gs("t6_rel", 8'h00, 3'b011, 1'b0, 1'b0);
        lock = 1'b0;
`else
        tick();
        chk_gs("t6_g3", 8'h08, 3'b011, 1'b0, 1'b1);
        for (int n = 0; n < MB; n++) begin
            tick();
            chk("t6_f3", {4'd0, f_valid, f}, 8'h0B);
        end
        tick();
        chk_gs("t6_limit", 8'h00, 3'b011, 1'b0, 1'b0);
        tick();
        chk_gs("t6_regrant", 8'h08, 3'b011, 1'b0, 1'b1);
        tick();
        chk("t6_f3b", {4'd0, f_valid, f}, 8'h0B);
        req = 8'h00;
        tick();
        chk_gs("t6_rel", 8'h00, 3'b011, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Shares the 8-input, 3-bit mux datapath (i0..i7 -> f) between 8 requesters using round-robin arbitration.
- Drives the three select lines s1, s2, s3 and a one-hot grant to the requesters.
- Registers the selected 3-bit word with a valid flag.
- Sits in front of the mux tree and supplies its selects. The downstream consumer sees a single arbitrated stream.

Parameters:
- MAX_BURST, 4: maximum consecutive data cycles one requester may hold the grant. Legal range 1..7.
- CNT_W, 3: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- req  input  8  request per requester; req[k] pairs with data ik
- i0..i7  input  3 each  requester data words
- gnt  output  8  one-hot grant, registered; all zero when idle
- s1  output  1  mux select; middle bit of the granted index
- s2  output  1  mux select; LSB of the granted index
- s3  output  1  mux select; MSB of the granted index
- f  output  3  registered selected data
- f_valid  output  1  f holds a word transferred this cycle
- busy  output  1  high while in state GRANT

Behaviour:
- Index mapping:
  - granted index k = {s3, s1, s2}.
  - s3 picks the upper group (i4..i7) versus the lower group (i0..i3).
  - {s1, s2} picks the word within the group.
  - The mux selects must always agree with gnt.
- Reset values (synchronous, rst high at an edge):
  - state = IDLE
  - gnt = 0; s1 = s2 = s3 = 0
  - f = 0; f_valid = 0; busy = 0
  - round-robin pointer ptr = 0; burst counter cnt = 0
  - rst overrides any operation in progress, including mid-burst. No data is emitted on the reset edge.
- State IDLE:
  - gnt = 0, f_valid = 0.
  - If req != 0 at an edge: pick the first set req bit scanning ptr, ptr+1, ..., 7, 0, ... (mod 8).
  - On that same edge: set gnt[k] = 1, set s3/s1/s2 = k, cnt = 0, go to GRANT.
  - If req == 0: stay in IDLE.
  - Grant latency: one edge after req is sampled.
- State GRANT (granted index k):
  - At each edge with req[k] = 1 and cnt < MAX_BURST: f <= ik, f_valid <= 1, cnt <= cnt + 1.
  - Release occurs at the edge where req[k] = 0, or at the edge after cnt reaches MAX_BURST (whichever comes first). On release:
    - gnt <= 0, f_valid <= 0
    - ptr <= (k + 1) mod 8, with wrap from 7 to 0
    - go to IDLE; s1/s2/s3 hold their last value
  - A requester transfers at most MAX_BURST words per grant.
  - Minimum gap between grants is one IDLE cycle, so arbitration always takes one cycle.
- f holds its value when f_valid = 0. Only f_valid qualifies f.
- Changes to other req bits during GRANT are ignored until the next IDLE arbitration.
- Changes to ik during GRANT are passed through at the sampling edge, with no extra latency.
- Fairness: after requester k is released, k has the lowest priority in the next arbitration. Any continuously asserted requester is granted within 8 grants.
- busy = (state == GRANT). It is registered together with the state.

Optional Feature:
- Macro: MUX8_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While lock = 1 in GRANT, the MAX_BURST limit is ignored and cnt saturates at MAX_BURST. Release happens only when req[k] drops.
  - If lock falls while cnt == MAX_BURST, release occurs at that edge.
  - lock is ignored in IDLE.
- When undefined: no lock port; burst limit always enforced.

Test Plan:
1. Reset, then req = 8'b0000_0100 with i2 = 3'b101 held for 3 cycles, then dropped.
   -> gnt = 8'h04 one edge later; {s3,s1,s2} = 010; f = 101 with f_valid high for 3 cycles; then gnt = 0 and ptr = 3.
2. req = 8'hFF held, MAX_BURST = 4, all ik = k.
   -> grants in order 0, 1, 2, ..., 7, 0. Each grant gives exactly 4 valid words equal to k, separated by one IDLE cycle. The {s3,s1,s2} sequence is 000, 001, ..., 111.
3. Wrap-around: ptr = 7 after releasing index 6, req = 8'b1000_0001.
   -> index 7 granted first ({s3,s1,s2} = 111), then index 0 (000).
4. rst asserted mid-burst (cnt = 2, index 5).
   -> next edge: gnt = 0, f = 0, f_valid = 0, busy = 0, ptr = 0. With req = 8'h21 afterwards, index 0 is granted first.
5. Requester drops after 1 word while others wait (req 8'h06, req[1] pulses for one cycle).
   -> index 1 transfers 1 word; index 2 is granted after one IDLE cycle.
6. With MUX8_ARB_LOCK_EN: lock = 1, req[3] held for 10 cycles, MAX_BURST = 4.
   -> 10 contiguous valid words from i3. Without the macro: 4 words, then release, then re-grant to 3 only if no other req is pending.
